// File: rtl/image_scale_ctrl.sv
// image_scale_ctrl: zoom command decode, frame-synchronous zoom commit,
// output pixel counters and mapped source-RAM read address for the scaler.
// Optional feature macro: SCALE_CMD_STEP_EN. When it is defined, opcodes 0x3/0x4
// step the zoom-in level with saturation. When it is undefined, those opcodes are ignored.
module image_scale_ctrl #(
    parameter int COL_PIXEL = 960,
    parameter int ROW_PIXEL = 540,
    parameter int ADDR_W    = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        command_in,
    input  logic              cmd_valid,
    input  logic              frame_start,
    input  logic              pix_valid,
    output logic [1:0]        zoom_in,
    output logic [1:0]        zoom_out,
    output logic              cfg_pending,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              rd_valid
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        APPLY   = 2'd2
    } state_t;

    state_t      state_r;
    logic [1:0]  sh_in_r;
    logic [1:0]  sh_out_r;
    logic [1:0]  commit_in_r;
    logic [1:0]  commit_out_r;
    logic [1:0]  nxt_sh_in_s;
    logic [1:0]  nxt_sh_out_s;
    logic        shadow_diff_s;
    logic        commit_diff_s;
    logic [10:0] hcnt_r;
    logic [9:0]  vcnt_r;
    logic [13:0] offx_s;
    logic [13:0] offy_s;
    logic [13:0] zx_s;
    logic [13:0] zy_s;
    logic [13:0] lim_x_s;
    logic [13:0] lim_y_s;
    logic [27:0] addr_full_s;
    logic        valid_s;

`ifdef SCALE_CMD_STEP_EN
    function automatic logic [1:0] sat_inc(input logic [1:0] v);
        return (v == 2'd3) ? 2'd3 : v + 2'd1;
    endfunction

    function automatic logic [1:0] sat_dec(input logic [1:0] v);
        return (v == 2'd0) ? 2'd0 : v - 2'd1;
    endfunction
`endif

    // Centering offset so a zoom-in window of size dim/n sits in the middle.
    function automatic logic [13:0] center_off(input int dim, input logic [1:0] zi);
        case (zi)
            2'd0:    return 14'd0;
            2'd1:    return 14'((dim * 1) / 2);
            2'd2:    return 14'((dim * 3) / 2);
            2'd3:    return 14'((dim * 7) / 2);
            default: return 14'd0;
        endcase
    endfunction

    // Next shadow setting after decoding the command of this cycle.
    always_comb begin
        nxt_sh_in_s  = sh_in_r;
        nxt_sh_out_s = sh_out_r;
        if (cmd_valid) begin
            case (command_in[7:4])
                4'h1: nxt_sh_in_s  = command_in[1:0];
                4'h2: nxt_sh_out_s = command_in[1:0];
`ifdef SCALE_CMD_STEP_EN
                4'h3: nxt_sh_in_s  = sat_inc(sh_in_r);
                4'h4: nxt_sh_in_s  = sat_dec(sh_in_r);
`endif
                4'hF: begin
                    nxt_sh_in_s  = 2'd0;
                    nxt_sh_out_s = 2'd0;
                end
                default: begin
                    nxt_sh_in_s  = sh_in_r;
                    nxt_sh_out_s = sh_out_r;
                end
            endcase
        end else begin
            nxt_sh_in_s  = sh_in_r;
            nxt_sh_out_s = sh_out_r;
        end
        shadow_diff_s = ({nxt_sh_in_s, nxt_sh_out_s} != {zoom_in, zoom_out});
        commit_diff_s = ({nxt_sh_in_s, nxt_sh_out_s} != {commit_in_r, commit_out_r});
    end

    // Shadow registers and commit FSM. The commit value is captured at frame_start
    // so a command that arrives in the same cycle waits for the next frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            sh_in_r      <= 2'd0;
            sh_out_r     <= 2'd0;
            commit_in_r  <= 2'd0;
            commit_out_r <= 2'd0;
            zoom_in      <= 2'd0;
            zoom_out     <= 2'd0;
            cfg_pending  <= 1'b0;
        end else begin
            sh_in_r  <= nxt_sh_in_s;
            sh_out_r <= nxt_sh_out_s;
            case (state_r)
                IDLE: begin
                    if (shadow_diff_s) begin
                        state_r     <= PENDING;
                        cfg_pending <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        cfg_pending <= 1'b0;
                    end
                end
                PENDING: begin
                    if (frame_start) begin
                        commit_in_r  <= sh_in_r;
                        commit_out_r <= sh_out_r;
                        state_r      <= APPLY;
                        cfg_pending  <= 1'b0;
                    end else if (!shadow_diff_s) begin
                        state_r     <= IDLE;
                        cfg_pending <= 1'b0;
                    end else begin
                        state_r     <= PENDING;
                        cfg_pending <= 1'b1;
                    end
                end
                APPLY: begin
                    zoom_in  <= commit_in_r;
                    zoom_out <= commit_out_r;
                    if (commit_diff_s) begin
                        state_r     <= PENDING;
                        cfg_pending <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        cfg_pending <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cfg_pending <= 1'b0;
                end
            endcase
        end
    end

    // Output pixel position counters; frame_start restarts the frame.
    always_ff @(posedge clk) begin
        if (!rst) begin
            hcnt_r <= 11'd0;
            vcnt_r <= 10'd0;
        end else if (frame_start) begin
            hcnt_r <= 11'd0;
            vcnt_r <= 10'd0;
        end else if (pix_valid) begin
            if (hcnt_r == 11'(COL_PIXEL - 1)) begin
                hcnt_r <= 11'd0;
                vcnt_r <= (vcnt_r == 10'(ROW_PIXEL - 1)) ? 10'd0 : vcnt_r + 10'd1;
            end else begin
                hcnt_r <= hcnt_r + 11'd1;
                vcnt_r <= vcnt_r;
            end
        end else begin
            hcnt_r <= hcnt_r;
            vcnt_r <= vcnt_r;
        end
    end

    // Map the output position to a source address using the active zoom.
    always_comb begin
        offx_s      = center_off(COL_PIXEL, zoom_in);
        offy_s      = center_off(ROW_PIXEL, zoom_in);
        zx_s        = (({3'd0, hcnt_r} + offx_s) >> zoom_in) << zoom_out;
        zy_s        = (({4'd0, vcnt_r} + offy_s) >> zoom_in) << zoom_out;
        addr_full_s = 28'(zy_s) * 28'(COL_PIXEL) + 28'(zx_s);
        lim_x_s     = 14'(COL_PIXEL) >> zoom_out;
        lim_y_s     = 14'(ROW_PIXEL) >> zoom_out;
        valid_s     = ({3'd0, hcnt_r} < lim_x_s) && ({4'd0, vcnt_r} < lim_y_s);
    end

    // Register the read address and its display qualifier.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_addr  <= {ADDR_W{1'b0}};
            rd_valid <= 1'b0;
        end else begin
            rd_addr  <= addr_full_s[ADDR_W-1:0];
            rd_valid <= valid_s;
        end
    end

endmodule

// File: tb/tb_image_scale_ctrl.sv
// Self-checking bench for image_scale_ctrl: a behavioural model predicts the
// registered address/valid for each cycle into a queue, checked one cycle later.
// A second, small instance (16x8) covers the full-frame counter wrap.
module tb_image_scale_ctrl;

    localparam int COL = 960;
    localparam int ROW = 540;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  command_in;
    logic        cmd_valid;
    logic        frame_start;
    logic        pix_valid;
    logic [1:0]  zoom_in, zoom_out, zoom_in_s, zoom_out_s;
    logic        cfg_pending, cfg_pending_s;
    logic [19:0] rd_addr;
    logic [6:0]  rd_addr_s;
    logic        rd_valid, rd_valid_s;

    int checks   = 0;
    int failures = 0;

    logic [20:0] exp_q[$];

    // model state
    int m_h, m_v, m_zi, m_zo, m_si, m_so, m_ci, m_co, m_st;

    image_scale_ctrl dut (
        .clk(clk), .rst(rst), .command_in(command_in), .cmd_valid(cmd_valid),
        .frame_start(frame_start), .pix_valid(pix_valid), .zoom_in(zoom_in),
        .zoom_out(zoom_out), .cfg_pending(cfg_pending), .rd_addr(rd_addr),
        .rd_valid(rd_valid)
    );

    image_scale_ctrl #(.COL_PIXEL(16), .ROW_PIXEL(8), .ADDR_W(7)) dut_small (
        .clk(clk), .rst(rst), .command_in(command_in), .cmd_valid(cmd_valid),
        .frame_start(frame_start), .pix_valid(pix_valid), .zoom_in(zoom_in_s),
        .zoom_out(zoom_out_s), .cfg_pending(cfg_pending_s), .rd_addr(rd_addr_s),
        .rd_valid(rd_valid_s)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int offs(input int dim, input int zi);
        return dim * ((1 << zi) - 1) / 2;
    endfunction

    // Predict this edge's registered outputs and advance the model by one clock.
    task automatic model_step();
        int zx, zy, ea, ni, no;
        logic ev;
        if (!rst) begin
            exp_q.push_back(21'd0);
            m_h = 0; m_v = 0; m_zi = 0; m_zo = 0; m_si = 0; m_so = 0;
            m_ci = 0; m_co = 0; m_st = 0;
        end else begin
            zx = ((m_h + offs(COL, m_zi)) >> m_zi) << m_zo;
            zy = ((m_v + offs(ROW, m_zi)) >> m_zi) << m_zo;
            ea = (zy * COL + zx) % (1 << 20);
            ev = (m_h < (COL >> m_zo)) && (m_v < (ROW >> m_zo));
            exp_q.push_back({ev, ea[19:0]});
            ni = m_si; no = m_so;
            if (cmd_valid) begin
                case (command_in[7:4])
                    4'h1: ni = int'(command_in[1:0]);
                    4'h2: no = int'(command_in[1:0]);
`ifdef SCALE_CMD_STEP_EN
                    4'h3: ni = (m_si < 3) ? m_si + 1 : 3;
                    4'h4: ni = (m_si > 0) ? m_si - 1 : 0;
`endif
                    4'hF: begin ni = 0; no = 0; end
                    default: ;
                endcase
            end
            case (m_st)
                0: if (ni != m_zi || no != m_zo) m_st = 1;
                1: begin
                    if (frame_start) begin
                        m_ci = m_si; m_co = m_so; m_st = 2;
                    end else if (ni == m_zi && no == m_zo) begin
                        m_st = 0;
                    end
                end
                default: begin
                    m_zi = m_ci; m_zo = m_co;
                    m_st = (ni != m_ci || no != m_co) ? 1 : 0;
                end
            endcase
            m_si = ni; m_so = no;
            if (frame_start) begin
                m_h = 0; m_v = 0;
            end else if (pix_valid) begin
                if (m_h == COL - 1) begin
                    m_h = 0;
                    m_v = (m_v == ROW - 1) ? 0 : m_v + 1;
                end else begin
                    m_h = m_h + 1;
                end
            end
        end
    endtask

    // One clock: predict, advance, then compare away from the edge.
    task automatic cyc();
        logic [20:0] e;
        model_step();
        @(posedge clk);
        #1;
        check("sb_depth", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_addr", rd_addr, e[19:0]);
            check("sb_valid", rd_valid, e[20]);
        end
        check("sb_zoom_in", zoom_in, m_zi);
        check("sb_zoom_out", zoom_out, m_zo);
        check("sb_pending", cfg_pending, m_st == 1);
    endtask

    task automatic cmd(input logic [7:0] c);
        command_in = c; cmd_valid = 1'b1;
        cyc();
        command_in = 8'h00; cmd_valid = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic pix(input int n);
        pix_valid = 1'b1;
        for (int i = 0; i < n; i++) cyc();
        pix_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b0; command_in = 8'h00; cmd_valid = 1'b0;
        frame_start = 1'b0; pix_valid = 1'b0;

        // 1. reset with random inputs
        for (int i = 0; i < 3; i++) begin
            command_in  = 8'($urandom);
            cmd_valid   = 1'($urandom);
            frame_start = 1'($urandom);
            pix_valid   = 1'($urandom);
            cyc();
        end
        check("rst_zoom_in", zoom_in, 0);
        check("rst_zoom_out", zoom_out, 0);
        check("rst_pending", cfg_pending, 0);
        check("rst_addr", rd_addr, 0);
        check("rst_valid", rd_valid, 0);
        check("rst_small_addr", rd_addr_s, 0);
        rst = 1'b1; command_in = 8'h00; cmd_valid = 1'b0;
        frame_start = 1'b0; pix_valid = 1'b0;

        // 2. deferred commit
        fs();
        pix(100);
        cmd(8'h11);
        check("defer_zoom_in", zoom_in, 0);
        check("defer_pending", cfg_pending, 1);
        pix(5);
        fs();
        cyc();
        check("commit_zoom_in", zoom_in, 1);
        check("commit_pending", cfg_pending, 0);

        // 3. zoom-in 2x map at origin
        cyc();
        check("zi1_addr", rd_addr, 129840);
        check("zi1_valid", rd_valid, 1);

        // 4. zoom-out 1/2 map
        cmd(8'h10);
        cmd(8'h21);
        fs();
        cyc();
        check("zo1_zoom_out", zoom_out, 1);
        pix(4 * COL + 10);
        cyc();
        check("zo1_addr", rd_addr, 7700);
        check("zo1_valid", rd_valid, 1);
        pix(470);
        cyc();
        check("zo1_edge_valid", rd_valid, 0);

        // 5. saturating step
        for (int i = 0; i < 4; i++) cmd(8'h30);
`ifdef SCALE_CMD_STEP_EN
        check("sat_pending", cfg_pending, 1);
        fs();
        cyc();
        check("sat_zoom_in", zoom_in, 3);
`else
        check("step_off_pending", cfg_pending, 0);
        check("step_off_zoom_in", zoom_in, 0);
`endif

        // 6. command colliding with frame_start
        cmd(8'h11);
        check("col_pre_pending", cfg_pending, 1);
        command_in = 8'h22; cmd_valid = 1'b1; frame_start = 1'b1;
        cyc();
        command_in = 8'h00; cmd_valid = 1'b0; frame_start = 1'b0;
        cyc();
        check("col_zoom_in", zoom_in, 1);
        check("col_zoom_out", zoom_out, 1);
        check("col_pending", cfg_pending, 1);
        fs();
        cyc();
        check("col2_zoom_out", zoom_out, 2);
        check("col2_pending", cfg_pending, 0);

        // 7. counter wrap on the small instance at zi=0, zo=0
        cmd(8'hF0);
        fs();
        cyc();
        check("wrap_zoom_small", {zoom_in_s, zoom_out_s}, 0);
        pix(17);
        cyc();
        check("wrap_row_addr", rd_addr_s, 17);
        pix(16 * 8 - 17);
        cyc();
        check("wrap_addr", rd_addr_s, 0);
        check("wrap_valid", rd_valid_s, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
